// File: rtl/sl_pkg.sv
// Shared types and constants for the SL transmit arbiter.
// Holds the arbiter state encoding and the legal word length range.
package sl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } sl_arb_state_t;

    localparam int SL_LEN_MIN = 8;
    localparam int SL_LEN_MAX = 32;
    localparam int SL_LEN_W   = 6;
    localparam int SL_ID_W    = 3;

    function automatic logic sl_len_ok(
        input logic [SL_LEN_W-1:0] len
    );
        return (len >= SL_LEN_W'(SL_LEN_MIN)) &&
               (len <= SL_LEN_W'(SL_LEN_MAX));
    endfunction

endpackage

// File: rtl/sl_rr_pick.sv
// Combinational round-robin picker for the SL transmit arbiter.
// Searches upward with wrap from rr_ptr+1; lowest offset wins.
module sl_rr_pick
    import sl_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [SL_ID_W-1:0] rr_ptr,
    output logic [N_REQ-1:0]   grant,
    output logic [SL_ID_W-1:0] idx,
    output logic               any
);

    // Walk offsets from farthest to nearest so the nearest hit is kept
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] &&
                    ((int'(rr_ptr) + off == i) ||
                     (int'(rr_ptr) + off == i + N_REQ))) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    idx      = SL_ID_W'(i);
                    any      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sl_tx_arbiter.sv
// Round-robin arbiter sequencing words into one SL serializer.
// Optional watchdog on WAIT_DONE enabled by macro SL_ARB_TIMEOUT_EN.
module sl_tx_arbiter
    import sl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ*6-1:0]      req_len,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    output logic [5:0]              tx_len,
    input  logic                    tx_done,
    output logic [2:0]              grant_id,
    output logic                    busy,
    output logic                    err_len,
    output logic [15:0]             words_sent,
    output logic                    timeout
);

    localparam int GAP_W    = (GAP_CYCLES > 1) ?
                              $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ?
                              GAP_CYCLES - 1 : 0;

    sl_arb_state_t        state;
    sl_arb_state_t        state_nxt;
    logic [SL_ID_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]     pick_oh;
    logic [SL_ID_W-1:0]   pick_idx;
    logic                 pick_any;
    logic                 accept;
    logic [DATA_W-1:0]    sel_data;
    logic [SL_LEN_W-1:0]  sel_len;
    logic                 sel_ok;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 wd_expire;

    sl_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign accept    = (state == IDLE) && enable && pick_any;
    assign req_ready = accept ? pick_oh : '0;
    assign tx_start  = (state == START);
    assign busy      = (state != IDLE);
    assign sel_ok    = sl_len_ok(sel_len);

    // Mux the winning requester's word and length
    always_comb begin
        sel_data = '0;
        sel_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_len  = req_len[i*6 +: 6];
            end
        end
    end

`ifdef SL_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state == WAIT_DONE) &&
                       (wd_cnt == WD_W'(TIMEOUT - 1));

    // Watchdog counts WAIT_DONE cycles; flags abort when no done arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= wd_expire && !tx_done;
            if (state == WAIT_DONE)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Next-state selection for the word sequencer
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && sel_ok)
                    state_nxt = START;
            end
            START: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done || wd_expire)
                    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == '0)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Capture the granted word and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= SL_ID_W'(N_REQ - 1);
            tx_data  <= '0;
            tx_len   <= '0;
            grant_id <= '0;
            err_len  <= 1'b0;
        end else begin
            err_len <= accept && !sel_ok;
            if (accept) begin
                rr_ptr   <= pick_idx;
                tx_data  <= sel_data;
                tx_len   <= sel_len;
                grant_id <= pick_idx;
            end
        end
    end

    // Completed-word counter; a watchdog abort does not count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            words_sent <= '0;
        else if ((state == WAIT_DONE) && tx_done)
            words_sent <= words_sent + 16'd1;
    end

    // Idle-gap countdown loaded when the word ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gap_cnt <= '0;
        else if (state == WAIT_DONE)
            gap_cnt <= GAP_W'(GAP_LOAD);
        else if ((state == GAP) && (gap_cnt != '0))
            gap_cnt <= gap_cnt - 1'b1;
    end

endmodule

// File: tb/tb_sl_tx_arbiter.sv
// Randomized bench for sl_tx_arbiter against a cycle-indexed model.
// Optional watchdog checks compile in with SL_ARB_TIMEOUT_EN.
module tb_sl_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int GAP = 16;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            enable = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N*6-1:0]  req_len = '0;
    logic [N-1:0]    req_ready;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic [5:0]      tx_len;
    logic            tx_done = 1'b0;
    logic [2:0]      grant_id;
    logic            busy;
    logic            err_len;
    logic [15:0]     words_sent;
    logic            timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // stimulus shadows applied at the next negedge
    logic [N-1:0] nv;
    logic         nen;
    logic [31:0]  wd [N];
    logic [5:0]   wl [N];

    // model: k is the cycle index since the last reset
    int          k;
    int          last;
    bit          in_word;
    int          free_at, start_at, err_at, done_at, tmo_at;
    bit          spur;
    logic [15:0] m_words;
    logic [31:0] m_data;
    logic [5:0]  m_len;
    logic [2:0]  m_gid;
    int          acc_id;
    logic [N-1:0] obs_rdy;
    logic [N-1:0] rdy_q [$];

    sl_tx_arbiter #(
        .N_REQ      (N),
        .DATA_W     (DW),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_len     (tx_len),
        .tx_done    (tx_done),
        .grant_id   (grant_id),
        .busy       (busy),
        .err_len    (err_len),
        .words_sent (words_sent),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs,
                         logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int from);
        for (int off = 1; off <= N; off++)
            if (v[(from + off) % N])
                return (from + off) % N;
        return -1;
    endfunction

    function automatic logic [5:0] bad_len();
        int r;
        r = $urandom_range(0, 38);
        return (r < 8) ? 6'(r) : 6'(r + 25);
    endfunction

    task automatic new_word(int i, bit good);
        wd[i] = $urandom;
        wl[i] = good ? 6'($urandom_range(8, 32)) : bad_len();
    endtask

    task automatic model_clear();
        k        = 0;
        last     = N - 1;
        in_word  = 0;
        free_at  = 0;
        start_at = -10;
        err_at   = -10;
        done_at  = -10;
        tmo_at   = -10;
        spur     = 0;
        m_words  = '0;
        m_data   = '0;
        m_len    = '0;
        m_gid    = '0;
        acc_id   = -1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        enable    = 1'b0;
        req_valid = '0;
        tx_done   = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        check("rst_len", tx_len, 0);
        check("rst_gid", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_len, 0);
        check("rst_words", words_sent, 0);
        check("rst_tmo", timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        nv  = '0;
        nen = 1'b1;
    endtask

    // one clock: drive, check against model, advance model
    task automatic step();
        int          w;
        bit          avail;
        bit          td;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        req_valid = nv;
        enable    = nen;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = wd[i];
            req_len[i*6 +: 6]    = wl[i];
        end
        td = (k == done_at) || (k == start_at && spur);
        tx_done = td;
        #1;
        avail   = !in_word && (k >= free_at);
        w       = pick(nv, last);
        exp_rdy = '0;
        if (avail && nen && w >= 0)
            exp_rdy[w] = 1'b1;
        obs_rdy = req_ready;
        if (req_ready != '0)
            rdy_q.push_back(req_ready);
        check("req_ready", req_ready, exp_rdy);
        check("tx_start", tx_start, k == start_at);
        check("err_len", err_len, k == err_at);
        check("busy", busy, !avail);
        check("words_sent", words_sent, m_words);
        check("tx_data", tx_data, m_data);
        check("tx_len", tx_len, m_len);
        check("grant_id", grant_id, m_gid);
        check("timeout", timeout, k == tmo_at);
        acc_id = -1;
        if (exp_rdy != '0) begin
            acc_id = w;
            last   = w;
            m_data = wd[w];
            m_len  = wl[w];
            m_gid  = 3'(w);
            if (wl[w] >= 8 && wl[w] <= 32) begin
                in_word  = 1;
                start_at = k + 1;
                spur     = ($urandom_range(0, 3) == 0);
                done_at  = k + 2 + $urandom_range(0, 7);
`ifdef SL_ARB_TIMEOUT_EN
                if ($urandom_range(0, 7) == 0)
                    done_at = -10;
`endif
            end else begin
                err_at = k + 1;
            end
        end else if (in_word && k > start_at) begin
            if (td) begin
                in_word = 0;
                free_at = k + 1 + GAP;
                m_words = m_words + 16'd1;
            end
`ifdef SL_ARB_TIMEOUT_EN
            else if (k == start_at + TMO) begin
                in_word = 0;
                free_at = k + 1 + GAP;
                tmo_at  = k + 1;
            end
`endif
        end
        k++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            wd[i] = '0;
            wl[i] = '0;
        end
        nv  = '0;
        nen = 1'b0;
        model_clear();
        pulse_reset();

        // single word, spurious done during START
        wd[0] = 32'hDEADBEEF;
        wl[0] = 6'd32;
        nv    = 4'b0001;
        step();
        check("t1_ready", obs_rdy, 4'b0001);
        nv      = '0;
        spur    = 1;
        done_at = start_at + 3;
        step();
        check("t1_start", tx_start, 1);
        check("t1_data", tx_data, 32'hDEADBEEF);
        check("t1_len", tx_len, 32);
        run(30);
        check("t1_words", words_sent, 1);

        // fairness with all requesters busy
        pulse_reset();
        rdy_q.delete();
        for (int i = 0; i < N; i++) begin
            wd[i] = $urandom;
            wl[i] = 6'd8;
        end
        nv = '1;
        for (int c = 0; c < 400 && rdy_q.size() < 5; c++) begin
            step();
            if (acc_id >= 0) begin
                wd[acc_id] = $urandom;
                done_at    = start_at + 2;
            end
        end
        check("t2_count", rdy_q.size(), 5);
        for (int j = 0; j < 5 && j < rdy_q.size(); j++)
            check("t2_order", rdy_q[j], 4'b0001 << (j % N));

        // bad length on requester 2, then search from 3
        pulse_reset();
        rdy_q.delete();
        nv    = 4'b0100;
        wl[2] = 6'd40;
        step();
        nv    = 4'b1010;
        wl[1] = 6'd12;
        wl[3] = 6'd16;
        step();
        check("t3_err", err_len, 1);
        check("t3_first", rdy_q.size() > 0 ? rdy_q[0] : 0, 4'b0100);
        check("t3_second", rdy_q.size() > 1 ? rdy_q[1] : 0, 4'b1000);
        nv = '0;
        run(30);

        // enable drop mid-word
        pulse_reset();
        nv    = 4'b0001;
        wl[0] = 6'd20;
        step();
        nv      = '0;
        done_at = start_at + 4;
        step();
        nen = 1'b0;
        step();
        nv    = 4'b0010;
        wl[1] = 6'd9;
        run(40);
        check("t4_words", words_sent, 1);
        nen = 1'b1;
        step();
        check("t4_resume", obs_rdy, 4'b0010);
        nv = '0;

        // async reset in WAIT_DONE
        nv    = 4'b0100;
        wl[2] = 6'd24;
        run(25);
        nv = '0;
        for (int c = 0; c < 20 && !(in_word && k > start_at + 1); c++)
            step();
        check("t6_in_wait", busy, 1);
        pulse_reset();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (acc_id == i)
                    nv[i] = 1'b0;
                if (!nv[i] && $urandom_range(0, 3) == 0) begin
                    nv[i] = 1'b1;
                    new_word(i, $urandom_range(0, 9) != 0);
                end
            end
            if ($urandom_range(0, 49) == 0)
                nen = !nen;
            if ($urandom_range(0, 999) == 0)
                pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
